ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single port of the 32x8 synchronous RAM between two requesters.
- Requester 0 is the binary search engine. Requester 1 is a loader/debug reader that initialises or inspects RAM contents.
- Arbitration is round-robin. A lock lets one requester own the RAM across a multi-access sequence, such as a full search.
- Registers all RAM-side signals and returns tagged read data with fixed latency.

Parameters:
ADDR_WIDTH, 5, RAM address width (32 words)
DATA_WIDTH, 8, RAM data width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 access request; held with its fields until gnt0
we0  input  1  requester 0 write (1) / read (0)
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
lock0  input  1  requester 0 requests continued ownership after this access
gnt0  output  1  combinational; access from requester 0 accepted this cycle
rvalid0  output  1  read data for requester 0 valid this cycle
req1, we1, addr1, wdata1, lock1  input  as above  requester 1 equivalents
gnt1, rvalid1  output  1  requester 1 equivalents
rdata  output  DATA_WIDTH  read data; equals ram_q; qualified by rvalid0/rvalid1
ram_address  output  ADDR_WIDTH  registered RAM address
ram_data  output  DATA_WIDTH  registered RAM write data
ram_wren  output  1  registered RAM write enable
ram_q  input  DATA_WIDTH  RAM read data (RAM registers its inputs; q valid the cycle after capture)

Behaviour:
- Reset (asynchronous, immediate):
  - FSM = IDLE, last_winner = 1, so port 0 wins the first contention.
  - ram_address = 0, ram_data = 0, ram_wren = 0.
  - Read-tag pipeline cleared; rvalid0 = rvalid1 = 0.
  - gnt0/gnt1 = 0 while reset is high.
- Grant is a combinational handshake.
  - gnt_i = 1 in the cycle req_i is accepted. The requester may change fields or drop req_i at that edge.
  - At most one gnt per cycle. One access is accepted per cycle maximum, so back-to-back grants are allowed.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE, only req_i high -> grant i.
  - IDLE, both high -> grant the port != last_winner.
  - OWN_i: only port i is eligible; req of the other port is ignored (no gnt).
  - Transitions on a grant to i: lock_i = 1 -> OWN_i; lock_i = 0 -> IDLE.
  - OWN_i with req_i = 0 and lock_i = 0 -> IDLE at the next edge.
  - OWN_i with req_i = 0 and lock_i = 1 -> stay in OWN_i (the other port stalls).
- last_winner is updated to i on every grant to i.
- RAM drive, at the edge ending grant cycle N:
  - ram_address <= addr_w, ram_data <= wdata_w, ram_wren <= we_w.
  - With no grant: ram_wren <= 0; ram_address and ram_data hold their values.
- Read latency:
  - A read granted in cycle N gives rvalid_w = 1 in cycle N+2, for exactly one cycle, with rdata = ram_q.
  - Tracked by a 2-stage {valid, id} shift register.
  - Writes produce no rvalid.
- Hazards:
  - A write granted in N followed by a read of the same address granted in N+1 returns the new data (RAM write completes before the read capture).
  - Read results from consecutive grants appear on consecutive cycles, in grant order.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset); ownership is released.
- No starvation in IDLE: a port with req held is granted within 2 cycles unless the other port holds a lock.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, no requests -> ram_wren=0, ram_address=0, gnt0=gnt1=rvalid0=rvalid1=0 throughout.
- Port 1 writes 8'hA5 to addr 7, then port 0 reads addr 7 the next cycle -> gnt1 in cycle N, gnt0 in N+1, rvalid0=1 with rdata=8'hA5 in N+3, rvalid1 never asserted.
- Both ports request reads continuously (addr0=3, addr1=9) from IDLE after reset -> grants alternate 0,1,0,1; rvalid alternates matching, two cycles behind each grant.
- Port 0 reads addrs 16, 8, 12 with lock0=1, lock0=0 on the last, while req1 is held high -> gnt1 stays low until after the third gnt0, then gnt1 on the next cycle; FSM returns to IDLE.
- Lock release without access: port 0 in OWN0 drops req0 and lock0 -> port 1 is granted on the second cycle after the drop.
- Reset asserted one cycle after a read grant -> rvalid0/rvalid1 stay 0 after reset; FSM in IDLE; next contention won by port 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter with lock for a shared 32x8 synchronous RAM port
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  lock0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_winner_q, last_winner_d;
    logic [ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0]   ram_data_q, ram_data_d;
    logic                    ram_wren_q, ram_wren_d;
    // Index 0 is the stage loaded at the grant edge, index 1 drives rvalid.
    logic [1:0]              rd_v_q, rd_v_d;
    logic [1:0]              rd_id_q, rd_id_d;

    logic                    any_gnt;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Grant decision: owner-only while locked, otherwise round-robin on contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        if (last_winner_q) gnt0 = 1'b1;
                        else               gnt1 = 1'b1;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end
    end

    // Mux the winning requester's fields toward the RAM registers.
    always_comb begin
        any_gnt   = gnt0 | gnt1;
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
    end

    // Next-state for ownership, fairness pointer, RAM drive and read-tag pipeline.
    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        if (gnt0) begin
            state_d       = lock0 ? OWN0 : IDLE;
            last_winner_d = 1'b0;
        end else if (gnt1) begin
            state_d       = lock1 ? OWN1 : IDLE;
            last_winner_d = 1'b1;
        end else if (state_q == OWN0 && !lock0) begin
            state_d = IDLE;
        end else if (state_q == OWN1 && !lock1) begin
            state_d = IDLE;
        end

        ram_address_d = any_gnt ? sel_addr  : ram_address_q;
        ram_data_d    = any_gnt ? sel_wdata : ram_data_q;
        ram_wren_d    = any_gnt & sel_we;

        rd_v_d  = {rd_v_q[0],  any_gnt & ~sel_we};
        rd_id_d = {rd_id_q[0], gnt1};
    end

    // State registers; reset drops ownership and discards in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_winner_q <= 1'b1;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            rd_v_q        <= 2'b00;
            rd_id_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            rd_v_q        <= rd_v_d;
            rd_id_q       <= rd_id_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign rvalid0     = rd_v_q[1] & ~rd_id_q[1];
    assign rvalid1     = rd_v_q[1] &  rd_id_q[1];
    assign rdata       = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed table-driven bench for ram_port_arbiter
module tb_ram_port_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic [4:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [7:0] ram_q;

    int total = 0;
    int bad   = 0;

    ram_port_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered inputs, q one cycle after capture; unwritten words read 8'h40+addr.
    logic [7:0] mem [32];
    logic [31:0] written = 32'h0;
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_address]     <= ram_data;
            written[ram_address] <= 1'b1;
        end
        ram_q <= written[ram_address] ? mem[ram_address] : (8'h40 + {3'b000, ram_address});
    end

    typedef struct {
        logic       rst;
        logic       r0, w0, l0, r1, w1, l1;
        logic [4:0] a0, a1;
        logic [7:0] d0, d1;
        logic       g0, g1, v0, v1;
        logic       crd;
        logic [7:0] rd;
        logic       cram;
        logic       wren;
        logic [4:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rst, int r0, int w0, int a0, int d0, int l0,
                                int r1, int w1, int a1, int d1, int l1,
                                int g0, int g1, int v0, int v1,
                                int crd, int rd, int cram, int wren, int addr);
        vec_t v;
        v.rst = rst[0];
        v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[4:0]; v.d0 = d0[7:0]; v.l0 = l0[0];
        v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[4:0]; v.d1 = d1[7:0]; v.l1 = l1[0];
        v.g0 = g0[0]; v.g1 = g1[0]; v.v0 = v0[0]; v.v1 = v1[0];
        v.crd = crd[0]; v.rd = rd[7:0];
        v.cram = cram[0]; v.wren = wren[0]; v.addr = addr[4:0];
        return v;
    endfunction

    task automatic chk1(string nm, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(int r0, int w0, int a0, int d0, int l0,
                         int r1, int w1, int a1, int d1, int l1);
        req0 = r0[0]; we0 = w0[0]; addr0 = a0[4:0]; wdata0 = d0[7:0]; lock0 = l0[0];
        req1 = r1[0]; we1 = w1[0]; addr1 = a1[4:0]; wdata1 = d1[7:0]; lock1 = l1[0];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(int idx, vec_t v);
        reset = v.rst;
        drive(v.r0, v.w0, v.a0, v.d0, v.l0, v.r1, v.w1, v.a1, v.d1, v.l1);
        @(negedge clk);
        chk1($sformatf("v%0d gnt0", idx), gnt0, v.g0);
        chk1($sformatf("v%0d gnt1", idx), gnt1, v.g1);
        chk1($sformatf("v%0d rvalid0", idx), rvalid0, v.v0);
        chk1($sformatf("v%0d rvalid1", idx), rvalid1, v.v1);
        if (v.crd) chk8($sformatf("v%0d rdata", idx), rdata, v.rd);
        if (v.cram) begin
            chk1($sformatf("v%0d ram_wren", idx), ram_wren, v.wren);
            chk8($sformatf("v%0d ram_address", idx), {3'b000, ram_address}, {3'b000, v.addr});
        end
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        drive(0,0,0,0,0, 0,0,0,0,0);

        // reset, then idle
        vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,0, 0,0,     1,0,0));
        vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,0, 0,0,     1,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,0, 0,0,     1,0,0));
        // port 1 writes A5 to addr 7, port 0 reads addr 7 next cycle
        vecs.push_back(mk(0, 0,0,0,0,0,      1,1,7,'hA5,0,   0,1,0,0, 0,0,     1,0,0));
        vecs.push_back(mk(0, 1,0,7,0,0,      0,0,0,0,0,      1,0,0,0, 0,0,     1,1,7));
        vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,0, 0,0,     1,0,7));
        vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,      0,0,1,0, 1,'hA5,  0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,0, 0,0,     0,0,0));
        // reset, then both ports read continuously: grants alternate 0,1,0,1
        vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,0, 0,0,     1,0,0));
        vecs.push_back(mk(0, 1,0,3,0,0,      1,0,9,0,0,      1,0,0,0, 0,0,     1,0,0));
        vecs.push_back(mk(0, 1,0,3,0,0,      1,0,9,0,0,      0,1,0,0, 0,0,     1,0,3));
        vecs.push_back(mk(0, 1,0,3,0,0,      1,0,9,0,0,      1,0,1,0, 1,'h43,  1,0,9));
        vecs.push_back(mk(0, 1,0,3,0,0,      1,0,9,0,0,      0,1,0,1, 1,'h49,  0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,      0,0,1,0, 1,'h43,  0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,1, 1,'h49,  0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,      0,0,0,0, 0,0,     0,0,0));

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Locked sequence: port 0 reads 16, 8, 12 while port 1 holds req
        drive(1,0,16,0,1, 1,0,1,0,0);
        @(negedge clk); chk1("lock L0 gnt0", gnt0, 1'b1); chk1("lock L0 gnt1", gnt1, 1'b0);
        next_cycle();
        drive(1,0,8,0,1, 1,0,1,0,0);
        @(negedge clk); chk1("lock L1 gnt0", gnt0, 1'b1); chk1("lock L1 gnt1", gnt1, 1'b0);
        next_cycle();
        drive(1,0,12,0,0, 1,0,1,0,0);
        @(negedge clk); chk1("lock L2 gnt0", gnt0, 1'b1); chk1("lock L2 gnt1", gnt1, 1'b0);
        chk1("lock L2 rvalid0", rvalid0, 1'b1); chk8("lock L2 rdata", rdata, 8'h50);
        next_cycle();
        drive(0,0,0,0,0, 1,0,1,0,0);
        @(negedge clk); chk1("lock L3 gnt0", gnt0, 1'b0); chk1("lock L3 gnt1", gnt1, 1'b1);
        chk1("lock L3 rvalid0", rvalid0, 1'b1); chk8("lock L3 rdata", rdata, 8'h48);
        next_cycle();
        drive(0,0,0,0,0, 0,0,0,0,0);
        @(negedge clk); chk1("lock L4 rvalid0", rvalid0, 1'b1); chk8("lock L4 rdata", rdata, 8'h4C);
        chk1("lock L4 rvalid1", rvalid1, 1'b0);
        next_cycle();
        @(negedge clk); chk1("lock L5 rvalid1", rvalid1, 1'b1); chk8("lock L5 rdata", rdata, 8'h41);
        chk1("lock L5 rvalid0", rvalid0, 1'b0);
        next_cycle();

        // Lock release without access: port 0 owns, stalls port 1, then drops
        drive(1,0,2,0,1, 1,0,5,0,0);
        @(negedge clk); chk1("rel R0 gnt0", gnt0, 1'b1); chk1("rel R0 gnt1", gnt1, 1'b0);
        next_cycle();
        drive(0,0,2,0,1, 1,0,5,0,0);
        @(negedge clk); chk1("rel R1 gnt1 stalled", gnt1, 1'b0);
        next_cycle();
        drive(0,0,2,0,0, 1,0,5,0,0);
        @(negedge clk); chk1("rel R2 gnt1 drop cycle", gnt1, 1'b0);
        next_cycle();
        @(negedge clk); chk1("rel R3 gnt1", gnt1, 1'b1); chk1("rel R3 gnt0", gnt0, 1'b0);
        next_cycle();

        // Reset one cycle after a read grant
        drive(1,0,4,0,0, 0,0,0,0,0);
        @(negedge clk); chk1("rst R4 gnt0", gnt0, 1'b1);
        next_cycle();
        reset = 1'b1;
        drive(1,0,4,0,0, 1,0,6,0,0);
        @(negedge clk);
        chk1("rst R5 gnt0", gnt0, 1'b0); chk1("rst R5 gnt1", gnt1, 1'b0);
        chk1("rst R5 rvalid0", rvalid0, 1'b0); chk1("rst R5 rvalid1", rvalid1, 1'b0);
        chk1("rst R5 ram_wren", ram_wren, 1'b0);
        next_cycle();
        reset = 1'b0;
        drive(0,0,0,0,0, 0,0,0,0,0);
        @(negedge clk);
        chk1("rst R6 rvalid0", rvalid0, 1'b0); chk1("rst R6 rvalid1", rvalid1, 1'b0);
        next_cycle();
        drive(1,0,4,0,0, 1,0,6,0,0);
        @(negedge clk);
        chk1("rst R7 gnt0", gnt0, 1'b1); chk1("rst R7 gnt1", gnt1, 1'b0);
        chk1("rst R7 rvalid0", rvalid0, 1'b0);
        next_cycle();
        drive(0,0,0,0,0, 0,0,0,0,0);
        @(negedge clk); chk1("rst R8 rvalid0", rvalid0, 1'b0);
        next_cycle();
        @(negedge clk); chk1("rst R9 rvalid0", rvalid0, 1'b1); chk8("rst R9 rdata", rdata, 8'h44);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
